// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with configurable width and depth.
// Provides an occupancy count, almost-full/almost-empty thresholds and
// registered overflow/underflow pulses. Read data is either registered
// (FWFT = 0) or first-word-fall-through (FWFT = 1).
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       write_en,
    input  logic                       read_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc;

    // Flags come from the registered count only, so they never depend
    // combinationally on the request inputs.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = write_en & ~full;
    assign rd_acc = read_en & ~empty;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer, count and error-pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= write_en & full;
            underflow_q <= read_en & empty;
        end
    end

    // Storage array; contents survive reset, but writes are blocked while
    // reset is held so a write coinciding with reset has no effect.
    always_ff @(posedge clk) begin
        if (reset_n && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem_q[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q;

            // Registered read port: loads the head word only on an accepted read.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rdata_q <= '0;
                end else if (rd_acc) begin
                    rdata_q <= mem_q[rd_ptr_q];
                end
            end

            assign data_out = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: a registered-read instance driven
// through a scoreboard model, plus a FWFT instance for fall-through checks.
module tb_sync_fifo_param;

    logic       clk;
    logic       reset_n;
    logic       write_en, read_en;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic       f_write_en, f_read_en;
    logic [7:0] f_data_in, f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb_q[$];
    int         m_count;
    logic [7:0] m_dout;
    bit         m_ovf, m_unf;

    sync_fifo_param dut (
        .clk(clk), .reset_n(reset_n),
        .write_en(write_en), .read_en(read_en), .data_in(data_in),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.FWFT(1)) dut_fwft (
        .clk(clk), .reset_n(reset_n),
        .write_en(f_write_en), .read_en(f_read_en), .data_in(f_data_in),
        .data_out(f_data_out), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle on the registered-read instance and advance the model.
    task automatic drive(input bit we, input bit re, input logic [7:0] d);
        bit full_b, empty_b, wa, ra;
        write_en = we;
        read_en  = re;
        data_in  = d;
        @(posedge clk);
        full_b  = (m_count == 8);
        empty_b = (m_count == 0);
        wa = we && !full_b;
        ra = re && !empty_b;
        if (ra) m_dout = sb_q.pop_front();
        if (wa) sb_q.push_back(d);
        m_count = m_count + int'(wa) - int'(ra);
        m_ovf = we && full_b;
        m_unf = re && empty_b;
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (count !== 4'd0)      begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %b expected 1", almost_empty); end
        n_checks++; if (full !== 1'b0)       begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b expected 0", almost_full); end
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got ovf=%b unf=%b expected 0 0", overflow, underflow); end
        n_checks++; if (data_out !== 8'd0)   begin n_fail++; $display("FAIL reset_dout: got %0d expected 0", data_out); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            n_checks++; if (count !== 4'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
            n_checks++; if (almost_empty !== (i <= 1)) begin n_fail++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, almost_empty, (i <= 1)); end
            n_checks++; if (almost_full !== (i >= 7)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full, (i >= 7)); end
            n_checks++; if (full !== (i == 8)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 8)); end
            n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, empty); end
        end
    endtask

    task automatic test_overflow_drain();
        drive(1'b1, 1'b0, 8'd99);
        n_checks++; if (overflow !== 1'b1 || m_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", count); end
        drive(1'b0, 1'b0, 8'd0);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 8'd0);
            n_checks++; if (data_out !== m_dout || data_out !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %0d expected %0d", i, data_out, m_dout); end
            n_checks++; if (count !== 4'(m_count)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, m_count); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", empty); end
        drive(1'b0, 1'b1, 8'd0);
        n_checks++; if (underflow !== 1'b1 || m_unf !== 1'b1) begin n_fail++; $display("FAIL unf_pulse: got %b expected 1", underflow); end
        n_checks++; if (data_out !== 8'd8) begin n_fail++; $display("FAIL unf_hold: got %0d expected 8", data_out); end
        drive(1'b0, 1'b0, 8'd0);
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b expected 0", underflow); end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, 8'(30 + i));
        drive(1'b1, 1'b1, 8'd77);
        n_checks++; if (count !== 4'd7) begin n_fail++; $display("FAIL sim_full_count: got %0d expected 7", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sim_full_ovf: got %b expected 1", overflow); end
        n_checks++; if (data_out !== 8'd31) begin n_fail++; $display("FAIL sim_full_data: got %0d expected 31", data_out); end
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 8'd0);
            n_checks++; if (data_out !== m_dout) begin n_fail++; $display("FAIL sim_drain[%0d]: got %0d expected %0d", i, data_out, m_dout); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sim_drained: got %b expected 1", empty); end
        drive(1'b1, 1'b1, 8'd55);
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL sim_empty_count: got %0d expected 1", count); end
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL sim_empty_unf: got %b expected 1", underflow); end
        drive(1'b0, 1'b1, 8'd0);
        n_checks++; if (data_out !== 8'd55) begin n_fail++; $display("FAIL sim_empty_data: got %0d expected 55", data_out); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL sim_empty_final: got %0d expected 0", count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(100 + i));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'd0);
            n_checks++; if (data_out !== 8'(100 + i)) begin n_fail++; $display("FAIL wrap_pre[%0d]: got %0d expected %0d", i, data_out, 100 + i); end
        end
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, 8'(i));
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full: got %b expected 1", full); end
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 8'd0);
            n_checks++; if (data_out !== m_dout || data_out !== 8'(i)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0d expected %0d", i, data_out, i); end
        end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL wrap_count: got %0d expected 0", count); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 8'd200);
        drive(1'b1, 1'b0, 8'd201);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'(202 + i));
            n_checks++; if (data_out !== m_dout) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, data_out, m_dout); end
            n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
        end
        drive(1'b0, 1'b1, 8'd0);
        drive(1'b0, 1'b1, 8'd0);
        n_checks++; if (data_out !== 8'd205) begin n_fail++; $display("FAIL b2b_last: got %0d expected 205", data_out); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(60 + i));
        drive(1'b0, 1'b1, 8'd0);
        #1;
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        m_count = 0;
        m_dout  = 8'd0;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty: got %b expected 1", empty); end
        n_checks++; if (data_out !== 8'd0) begin n_fail++; $display("FAIL rst_mid_dout: got %0d expected 0", data_out); end
        write_en = 1'b1;
        data_in  = 8'd77;
        @(posedge clk);
        @(negedge clk);
        write_en = 1'b0;
        reset_n  = 1'b1;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_ignore: got %0d expected 0", count); end
        drive(1'b1, 1'b0, 8'd20);
        drive(1'b0, 1'b1, 8'd0);
        n_checks++; if (data_out !== 8'd20) begin n_fail++; $display("FAIL rst_mid_data: got %0d expected 20", data_out); end
    endtask

    task automatic test_fwft();
        logic [7:0] exp_q[$];
        logic [7:0] exp;
        f_write_en = 1'b1; f_data_in = 8'd10;
        @(posedge clk); #1;
        exp_q.push_back(8'd10);
        f_write_en = 1'b0;
        n_checks++; if (f_data_out !== exp_q[0] || f_data_out !== 8'd10) begin n_fail++; $display("FAIL fwft_first: got %0d expected 10", f_data_out); end
        n_checks++; if (f_empty !== 1'b0) begin n_fail++; $display("FAIL fwft_empty: got %b expected 0", f_empty); end
        f_write_en = 1'b1; f_data_in = 8'd11;
        @(posedge clk); #1;
        exp_q.push_back(8'd11);
        f_write_en = 1'b0;
        n_checks++; if (f_data_out !== 8'd10) begin n_fail++; $display("FAIL fwft_head_hold: got %0d expected 10", f_data_out); end
        f_read_en = 1'b1;
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        f_read_en = 1'b0;
        n_checks++; if (f_data_out !== exp_q[0] || f_data_out !== 8'd11) begin n_fail++; $display("FAIL fwft_pop: got %0d expected 11 (popped %0d)", f_data_out, exp); end
        n_checks++; if (f_count !== 4'd1) begin n_fail++; $display("FAIL fwft_count: got %0d expected 1", f_count); end
        f_read_en = 1'b1;
        @(posedge clk); #1;
        f_read_en = 1'b0;
        n_checks++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_drained: got %b expected 1", f_empty); end
    endtask

    initial begin
        reset_n = 1'b0;
        write_en = 1'b0; read_en = 1'b0; data_in = 8'd0;
        f_write_en = 1'b0; f_read_en = 1'b0; f_data_in = 8'd0;
        m_count = 0; m_dout = 8'd0; m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_simultaneous();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_fwft();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the successor to the fixed 8x8 `sync_fifo`: configurable width and depth, occupancy count, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses. It offers a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer blocks in the same clock domain and is the default buffering element for new datapaths.

## Interface
- `DATA_WIDTH`, 8, width of each stored word.
- `DEPTH`, 8, number of entries; power of two, >= 2.
- `AF_THRESH`, DEPTH-1, `almost_full` asserts when count >= AF_THRESH; legal range 1..DEPTH.
- `AE_THRESH`, 1, `almost_empty` asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- `FWFT`, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `write_en` input 1: write request.
- `read_en` input 1: read request.
- `data_in` input DATA_WIDTH: write data.
- `data_out` output DATA_WIDTH: read data.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `almost_full` output 1: count >= AF_THRESH.
- `almost_empty` output 1: count <= AE_THRESH.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: one-cycle pulse for a rejected write.
- `underflow` output 1: one-cycle pulse for a rejected read.

## Operation
- Accepted write: `wr_acc = write_en & ~full`. Accepted read: `rd_acc = read_en & ~empty`. Both use flags sampled before the edge.
- On `wr_acc`: `mem[wr_ptr] <= data_in`, and `wr_ptr` increments modulo DEPTH.
- On `rd_acc`: `rd_ptr` increments modulo DEPTH. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Count update:
  - +1 on `wr_acc` alone.
  - -1 on `rd_acc` alone.
  - Unchanged when both occur, or when neither occurs.
- Simultaneous write and read:
  - When full: the read is accepted, the write is rejected (overflow pulse), and count becomes DEPTH-1.
  - When empty: the write is accepted, the read is rejected (underflow pulse), and count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- `full`, `empty`, `almost_full` and `almost_empty` are decoded from the registered `count` only. They never depend combinationally on `write_en` or `read_en`.
- `overflow` is registered: it is 1 for exactly the cycle after an edge where `write_en & full` held. `underflow` behaves the same way for `read_en & empty`. Back-to-back violations give continuous assertion.
- Rejected operations leave memory, pointers and count unchanged.
- `FWFT = 0`: `data_out` is registered. On `rd_acc` it loads `mem[rd_ptr]`; otherwise it holds its value, including across writes and rejected reads.
- `FWFT = 1`: `data_out = mem[rd_ptr]` combinationally, so the head word is visible whenever `~empty`. `read_en` pops the head. The value shown while empty is don't-care.
- Reset (`reset_n` = 0, takes effect immediately, asynchronously):
  - Pointers, `count`, `overflow` and `underflow` go to 0.
  - Registered `data_out` goes to 0.
  - `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data. Any write or read in the same cycle is ignored.
- Deassertion of `reset_n` must be synchronous to `clk` by the system. The block begins accepting writes on the first rising edge after deassertion.

## Timing
- Write-to-flags: with `wr_acc` at edge N, `count`, `empty` and the almost flags reflect the write after edge N.
- Write-to-read latency, `FWFT = 0`:
  - Word written at edge N.
  - `read_en` can be accepted at edge N+1.
  - Data appears on `data_out` after edge N+1.
- Write-to-read latency, `FWFT = 1`: the word written at edge N appears on `data_out` after edge N, with `empty` low.
- Sustained throughput: one write and one read per cycle when neither full nor empty.
- Error pulses lag the offending request by one edge.

## Test plan
All scenarios use defaults (DEPTH = 8, DATA_WIDTH = 8, AF_THRESH = 7, AE_THRESH = 1, FWFT = 0) unless stated.
- Fill: write 1..8 on consecutive cycles from reset -> `count` goes 1..8; `almost_empty` drops after the 2nd write; `almost_full` rises after the 7th; `full` = 1 after the 8th.
- Overflow then drain: write 99 while full -> `overflow` pulses for 1 cycle and `count` stays 8. Then read 8 times -> `data_out` shows 1..8 in order and `empty` = 1 after the 8th read. A 9th read -> `underflow` pulses and `data_out` holds 8.
- Simultaneous edge cases:
  - Full with `write_en` = `read_en` = 1 -> `count` 7, `overflow` pulses.
  - Empty with both high and `data_in` = 55 -> `count` 1, `underflow` pulses; the next read returns 55.
- Wrap-around: write 3 / read 3, then write 1..8 and read 8 -> data returns 1..8 intact across the pointer wrap; `count` returns to 0.
- Reset mid-operation: with 3 words stored, drive `reset_n` low asynchronously between edges -> `count` = 0, `empty` = 1 and `data_out` = 0 immediately. The next write of 20 followed by a read returns 20.
- FWFT = 1: write 10 -> `data_out` = 10 after the same edge with `empty` = 0. Write 11, then read -> `data_out` = 11 after the read edge.
